// File: rtl/azadi_pad_mux_if.sv
`default_nettype none
// ============================================================================
// Module   : azadi_pad_mux_if
// Brief    : Wishbone classic slave bundle for the pad multiplexer register port.
// Revision : 1.0 - initial release
// ============================================================================
interface azadi_pad_mux_if;
  logic        wbs_stb_i;
  logic        wbs_cyc_i;
  logic        wbs_we_i;
  logic [3:0]  wbs_sel_i;
  logic [31:0] wbs_adr_i;
  logic [31:0] wbs_dat_i;
  logic        wbs_ack_o;
  logic [31:0] wbs_dat_o;

  modport master (
    output wbs_stb_i, wbs_cyc_i, wbs_we_i, wbs_sel_i, wbs_adr_i, wbs_dat_i,
    input  wbs_ack_o, wbs_dat_o
  );

  modport slave (
    input  wbs_stb_i, wbs_cyc_i, wbs_we_i, wbs_sel_i, wbs_adr_i, wbs_dat_i,
    output wbs_ack_o, wbs_dat_o
  );
endinterface
`default_nettype wire

// File: rtl/azadi_pad_mux.sv
`default_nettype none
// ============================================================================
// Module   : azadi_pad_mux
// Brief    : Wishbone-programmable per-pad function multiplexer with input
//            synchroniser and sticky pin-map lock.
// Revision : 1.0 - initial release
// ============================================================================
module azadi_pad_mux #(
  parameter int          NUM_PADS    = 38,
  parameter int          NUM_FUNC    = 4,
  parameter int          SYNC_STAGES = 2,
  parameter logic [31:0] BASE_ADDR   = 32'h3000_0000
) (
  input  wire logic                         wb_clk_i,
  input  wire logic                         wb_rst_i,
  azadi_pad_mux_if.slave                    wb,
  input  wire logic [NUM_FUNC*NUM_PADS-1:0] func_out_i,
  input  wire logic [NUM_FUNC*NUM_PADS-1:0] func_oe_i,
  output logic      [NUM_FUNC*NUM_PADS-1:0] func_in_o,
  input  wire logic [NUM_PADS-1:0]          io_in,
  output logic      [NUM_PADS-1:0]          io_out,
  output logic      [NUM_PADS-1:0]          io_oeb,
  output logic                              locked_o
);

  localparam int         c_fw         = $clog2(NUM_FUNC);
  localparam logic [8:0] c_off_lock   = 9'h100;
  localparam logic [8:0] c_off_in_lo  = 9'h104;
  localparam logic [8:0] c_off_in_hi  = 9'h108;

  logic [c_fw-1:0]     r_sel [NUM_PADS];
  logic                r_lock;
  logic                r_ack;
  logic [31:0]         r_dat;
  logic [NUM_PADS-1:0] r_sync [SYNC_STAGES];

  logic [NUM_PADS-1:0] w_s_in;
  logic [63:0]         w_in_ext;
  logic                w_req;
  logic                w_hit;
  logic                w_we;
  logic                w_sel_space;
  logic [8:0]          w_off;
  logic [5:0]          w_word;
  logic [7:0]          w_byte;
  logic [c_fw-1:0]     w_sel_wdata;
  logic [31:0]         w_rdata;
  logic                w_unused;

  // Only byte lane 0 carries register fields.
  assign w_unused = ^{wb.wbs_dat_i[31:8], wb.wbs_sel_i[3:1]};

  assign w_s_in = r_sync[SYNC_STAGES-1];

  if (NUM_PADS < 64) begin : g_ext_pad
    assign w_in_ext = {{(64-NUM_PADS){1'b0}}, w_s_in};
  end else begin : g_ext_full
    assign w_in_ext = w_s_in;
  end

  assign w_req       = wb.wbs_stb_i & wb.wbs_cyc_i & ~r_ack;
  assign w_hit       = (wb.wbs_adr_i[31:9] == BASE_ADDR[31:9]);
  assign w_off       = wb.wbs_adr_i[8:0];
  assign w_word      = wb.wbs_adr_i[7:2];
  assign w_sel_space = w_hit & ~wb.wbs_adr_i[8] & (wb.wbs_adr_i[1:0] == 2'b00);
  assign w_we        = w_req & wb.wbs_we_i & wb.wbs_sel_i[0] & w_hit;
  assign w_byte      = wb.wbs_dat_i[7:0];

  // Out-of-range selections are stored as function 0 so readback matches behaviour.
  assign w_sel_wdata = (int'(w_byte) >= NUM_FUNC) ? '0 : w_byte[c_fw-1:0];

  always_comb begin
    w_rdata = '0;
    if (w_sel_space) begin
      for (int p = 0; p < NUM_PADS; p++) begin
        if (int'(w_word) == p) begin
          w_rdata = 32'(r_sel[p]);
        end
      end
    end else if (w_hit) begin
      case (w_off)
        c_off_lock:  w_rdata = {31'b0, r_lock};
        c_off_in_lo: w_rdata = w_in_ext[31:0];
        c_off_in_hi: w_rdata = w_in_ext[63:32];
        default:     w_rdata = '0;
      endcase
    end
  end

  always_ff @(posedge wb_clk_i) begin
    if (wb_rst_i) begin
      r_ack  <= 1'b0;
      r_dat  <= '0;
      r_lock <= 1'b0;
      for (int p = 0; p < NUM_PADS; p++) begin
        r_sel[p] <= '0;
      end
    end else begin
      r_ack <= w_req;
      r_dat <= w_req ? w_rdata : '0;
      if (w_we && (w_off == c_off_lock) && wb.wbs_dat_i[0]) begin
        r_lock <= 1'b1;
      end
      if (w_we && w_sel_space && !r_lock) begin
        for (int p = 0; p < NUM_PADS; p++) begin
          if (int'(w_word) == p) begin
            r_sel[p] <= w_sel_wdata;
          end
        end
      end
    end
  end

  always_ff @(posedge wb_clk_i) begin
    if (wb_rst_i) begin
      for (int s = 0; s < SYNC_STAGES; s++) begin
        r_sync[s] <= '0;
      end
    end else begin
      r_sync[0] <= io_in;
      for (int s = 1; s < SYNC_STAGES; s++) begin
        r_sync[s] <= r_sync[s-1];
      end
    end
  end

  assign wb.wbs_ack_o = r_ack;
  assign wb.wbs_dat_o = r_dat;
  assign locked_o     = r_lock;

  for (genvar p = 0; p < NUM_PADS; p++) begin : g_pad
    logic [c_fw-1:0] w_eff;
    logic            w_out;
    logic            w_oe;

    // Function 0 never drives the pad; it is the input-only / GPIO read-back slot.
    always_comb begin
      w_eff = (int'(r_sel[p]) < NUM_FUNC) ? r_sel[p] : '0;
      w_out = 1'b0;
      w_oe  = 1'b0;
      for (int f = 1; f < NUM_FUNC; f++) begin
        if (int'(w_eff) == f) begin
          w_out = func_out_i[f*NUM_PADS+p];
          w_oe  = func_oe_i[f*NUM_PADS+p];
        end
      end
    end

    assign io_out[p] = w_out;
    assign io_oeb[p] = ~w_oe;

    for (genvar f = 0; f < NUM_FUNC; f++) begin : g_func
      assign func_in_o[f*NUM_PADS+p] = (int'(w_eff) == f) ? w_s_in[p] : 1'b0;
    end
  end

endmodule
`default_nettype wire

// File: tb/tb_azadi_pad_mux.sv
`default_nettype none
// ============================================================================
// Module   : tb_azadi_pad_mux
// Brief    : Directed self-checking bench for azadi_pad_mux (default parameters).
// Revision : 1.0 - initial release
// ============================================================================
module tb_azadi_pad_mux;
  localparam int          NP   = 38;
  localparam int          NF   = 4;
  localparam logic [31:0] BASE = 32'h3000_0000;

  logic clk = 1'b0;
  logic rst;
  always #5 clk = ~clk;

  azadi_pad_mux_if wb ();

  logic [NF*NP-1:0] func_out;
  logic [NF*NP-1:0] func_oe;
  logic [NF*NP-1:0] func_in;
  logic [NP-1:0]    io_in;
  logic [NP-1:0]    io_out;
  logic [NP-1:0]    io_oeb;
  logic             locked;

  azadi_pad_mux #(
    .NUM_PADS    (NP),
    .NUM_FUNC    (NF),
    .SYNC_STAGES (2),
    .BASE_ADDR   (BASE)
  ) dut (
    .wb_clk_i   (clk),
    .wb_rst_i   (rst),
    .wb         (wb.slave),
    .func_out_i (func_out),
    .func_oe_i  (func_oe),
    .func_in_o  (func_in),
    .io_in      (io_in),
    .io_out     (io_out),
    .io_oeb     (io_oeb),
    .locked_o   (locked)
  );

  int n_checks = 0;
  int n_fail   = 0;

  task automatic check(input string tag, input logic [63:0] obs, input logic [63:0] exp);
    n_checks++;
    if (obs !== exp) begin
      n_fail++;
      $display("FAIL %s: got 0x%0h expected 0x%0h", tag, obs, exp);
    end
  endtask

  task automatic wb_cycle(input logic [31:0] adr, input logic we, input logic [31:0] dat,
                          input logic [3:0] sel, output logic [31:0] rdat);
    int n;
    @(posedge clk); #1;
    wb.wbs_adr_i = adr;
    wb.wbs_we_i  = we;
    wb.wbs_dat_i = dat;
    wb.wbs_sel_i = sel;
    wb.wbs_stb_i = 1'b1;
    wb.wbs_cyc_i = 1'b1;
    n = 0;
    do begin
      @(posedge clk); #1;
      n++;
    end while (!wb.wbs_ack_o && n < 8);
    check("ack_latency", 64'(n), 64'd1);
    rdat = wb.wbs_dat_o;
    wb.wbs_stb_i = 1'b0;
    wb.wbs_cyc_i = 1'b0;
    wb.wbs_we_i  = 1'b0;
  endtask

  task automatic wb_write(input logic [31:0] adr, input logic [31:0] dat, input logic [3:0] sel);
    logic [31:0] dummy;
    wb_cycle(adr, 1'b1, dat, sel, dummy);
  endtask

  task automatic wb_read(input logic [31:0] adr, output logic [31:0] rdat);
    wb_cycle(adr, 1'b0, 32'h0, 4'hF, rdat);
  endtask

  initial begin
    #200000;
    $display("FAIL watchdog: got timeout expected finish");
    $fatal(1, "watchdog expired");
  end

  initial begin
    logic [31:0] r;
    logic [5:0]  acks;
    logic        late_ack;

    wb.wbs_stb_i = 1'b0;
    wb.wbs_cyc_i = 1'b0;
    wb.wbs_we_i  = 1'b0;
    wb.wbs_sel_i = 4'h0;
    wb.wbs_adr_i = 32'h0;
    wb.wbs_dat_i = 32'h0;
    func_out     = '0;
    func_oe      = '0;
    io_in        = '1;
    rst          = 1'b1;

    // Reset state
    repeat (3) @(posedge clk);
    #1 rst = 1'b0;
    check("rst_io_oeb", 64'(io_oeb), 64'h3F_FFFF_FFFF);
    check("rst_io_out", 64'(io_out), 64'h0);
    check("rst_ack", 64'(wb.wbs_ack_o), 64'h0);
    check("rst_dat", 64'(wb.wbs_dat_o), 64'h0);
    check("rst_func_in", 64'(|func_in), 64'h0);
    check("rst_locked", 64'(locked), 64'h0);
    repeat (3) @(posedge clk);
    wb_read(BASE + 32'h104, r);
    check("in_lo_all1", 64'(r), 64'hFFFF_FFFF);
    wb_read(BASE + 32'h108, r);
    check("in_hi_all1", 64'(r), 64'h3F);
    check("f0_readback_p0", 64'(func_in[0]), 64'h1);

    // Route pad 4 to function 2
    func_out[2*NP+4] = 1'b1;
    func_oe[2*NP+4]  = 1'b1;
    func_oe[1*NP+4]  = 1'b1;
    #1;
    check("route_pre_oeb", 64'(io_oeb[4]), 64'h1);
    wb_write(BASE + 32'h010, 32'h2, 4'hF);
    check("route_io_out", 64'(io_out[4]), 64'h1);
    check("route_io_oeb", 64'(io_oeb[4]), 64'h0);
    wb_read(BASE + 32'h010, r);
    check("route_sel_rd", 64'(r), 64'h2);

    // Input synchroniser on pad 10, function 3
    io_in[10] = 1'b0;
    wb_write(BASE + 32'h028, 32'h3, 4'hF);
    repeat (3) @(posedge clk);
    #1 check("sync_low", 64'(func_in[3*NP+10]), 64'h0);
    @(posedge clk); #1;
    io_in[10] = 1'b1;
    @(posedge clk); #1;
    check("sync_t1", 64'(func_in[3*NP+10]), 64'h0);
    @(posedge clk); #1;
    check("sync_t2", 64'(func_in[3*NP+10]), 64'h1);
    check("sync_f1_zero", 64'(func_in[1*NP+10]), 64'h0);
    check("sync_f0_zero", 64'(func_in[0*NP+10]), 64'h0);
    check("sync_p11_f0", 64'(func_in[0*NP+11]), 64'h1);
    wb_read(BASE + 32'h104, r);
    check("sync_in_lo", 64'(r), 64'hFFFF_FFFF);

    // Decode edges
    wb_write(BASE + 32'h094, 32'h3, 4'hF);
    wb_read(BASE + 32'h094, r);
    check("sel37_rd", 64'(r), 64'h3);
    wb_write(BASE + 32'h098, 32'h3, 4'hF);
    wb_read(BASE + 32'h098, r);
    check("p38_rd", 64'(r), 64'h0);
    wb_write(BASE + 32'h200, 32'h3, 4'hF);
    wb_read(BASE + 32'h200, r);
    check("outside_rd", 64'(r), 64'h0);
    wb_read(BASE + 32'h000, r);
    check("outside_no_alias", 64'(r), 64'h0);
    wb_write(BASE + 32'h010, 32'h1, 4'b1110);
    wb_read(BASE + 32'h010, r);
    check("bytesel_rd", 64'(r), 64'h2);
    func_out[1*NP+5] = 1'b1;
    func_oe[1*NP+5]  = 1'b1;
    wb_write(BASE + 32'h014, 32'h1, 4'hF);
    check("p5_f1_out", 64'(io_out[5]), 64'h1);
    check("p5_f1_oeb", 64'(io_oeb[5]), 64'h0);
    wb_write(BASE + 32'h014, 32'h5, 4'hF);
    check("p5_sel5_out", 64'(io_out[5]), 64'h0);
    check("p5_sel5_oeb", 64'(io_oeb[5]), 64'h1);
    check("p5_sel5_f1_in", 64'(func_in[1*NP+5]), 64'h0);
    check("p5_sel5_f0_in", 64'(func_in[0*NP+5]), 64'h1);

    // Back-to-back handshake with stb/cyc held
    @(posedge clk); #1;
    wb.wbs_adr_i = BASE + 32'h010;
    wb.wbs_we_i  = 1'b0;
    wb.wbs_sel_i = 4'hF;
    wb.wbs_stb_i = 1'b1;
    wb.wbs_cyc_i = 1'b1;
    for (int i = 0; i < 6; i++) begin
      acks[i] = wb.wbs_ack_o;
      check($sformatf("hold_dat%0d", i), 64'(wb.wbs_dat_o), (i % 2 == 1) ? 64'h2 : 64'h0);
      @(posedge clk); #1;
    end
    check("hold_ack_pattern", 64'(acks), 64'b101010);
    wb.wbs_cyc_i = 1'b0;
    late_ack = 1'b0;
    for (int i = 0; i < 3; i++) begin
      @(posedge clk); #1;
      late_ack = late_ack | wb.wbs_ack_o;
    end
    check("no_ack_cyc0", 64'(late_ack), 64'h0);
    wb.wbs_stb_i = 1'b0;

    // Lock
    wb_write(BASE + 32'h100, 32'h1, 4'hF);
    check("locked_set", 64'(locked), 64'h1);
    wb_read(BASE + 32'h100, r);
    check("lock_rd", 64'(r), 64'h1);
    wb_write(BASE + 32'h010, 32'h1, 4'hF);
    wb_read(BASE + 32'h010, r);
    check("locked_sel_rd", 64'(r), 64'h2);
    wb_write(BASE + 32'h100, 32'h0, 4'hF);
    check("lock_sticky", 64'(locked), 64'h1);
    @(posedge clk); #1 rst = 1'b1;
    @(posedge clk); #1 rst = 1'b0;
    check("lock_cleared", 64'(locked), 64'h0);
    check("post_rst_oeb4", 64'(io_oeb[4]), 64'h1);
    wb_read(BASE + 32'h010, r);
    check("post_rst_sel_rd", 64'(r), 64'h0);

    // Reset during a pending request drops it
    @(posedge clk); #1;
    wb.wbs_adr_i = BASE + 32'h010;
    wb.wbs_stb_i = 1'b1;
    wb.wbs_cyc_i = 1'b1;
    rst          = 1'b1;
    @(posedge clk); #1;
    check("rst_drop_ack", 64'(wb.wbs_ack_o), 64'h0);
    rst          = 1'b0;
    wb.wbs_stb_i = 1'b0;
    wb.wbs_cyc_i = 1'b0;
    @(posedge clk); #1;
    check("rst_drop_ack2", 64'(wb.wbs_ack_o), 64'h0);

    $display("TB_RESULT checks=%0d failures=%0d", n_checks, n_fail);
    $finish;
  end

endmodule
`default_nettype wire

// File: doc/azadi_pad_mux.md
# azadi_pad_mux

Parametrised, Wishbone-programmable pad multiplexer for the Caravel user area. Each of NUM_PADS pads is routed at run time to one of NUM_FUNC peripheral functions (JTAG, SPI, UART, PWM, GPIO, …) by a per-pad function-select register. Pad inputs are synchronised before fan-out, and a sticky lock bit freezes the pin map. It sits between the Caravel `io_*`/`wbs_*` ports and the SoC peripherals, replacing fixed pad assignments.

## Interface
- NUM_PADS, 38, pads handled (1..64)
- NUM_FUNC, 4, functions per pad (2..16); FW = $clog2(NUM_FUNC)
- SYNC_STAGES, 2, input synchroniser depth (2..3)
- BASE_ADDR, 32'h3000_0000, Wishbone base; block decodes 512 B window

- wb_clk_i  in  1  sole clock
- wb_rst_i  in  1  synchronous reset, active-high
- wbs_stb_i, wbs_cyc_i, wbs_we_i  in  1  Wishbone classic strobe/cycle/write
- wbs_sel_i  in  4  byte enables
- wbs_adr_i  in  32  byte address
- wbs_dat_i  in  32  write data
- wbs_ack_o  out  1  acknowledge
- wbs_dat_o  out  32  read data
- func_out_i  in  NUM_FUNC*NUM_PADS  function f drive for pad p at bit f*NUM_PADS+p
- func_oe_i  in  NUM_FUNC*NUM_PADS  function output enable, active-high, same packing
- func_in_o  out  NUM_FUNC*NUM_PADS  synchronised pad input to function f, same packing
- io_in  in  NUM_PADS  pad inputs
- io_out  out  NUM_PADS  pad outputs
- io_oeb  out  NUM_PADS  pad output enable, active-low
- locked_o  out  1  lock status

## Operation
- Register map, offsets from BASE_ADDR:
  - 0x000 + 4·p, p < NUM_PADS: SEL[p], bits [FW-1:0], R/W; other bits read 0.
  - 0x100: LOCK, bit0, write-1-to-set, sticky until reset.
  - 0x104: IN_LO, RO, synchronised io_in[31:0].
  - 0x108: IN_HI, RO, synchronised io_in[NUM_PADS-1:32]; 0 if NUM_PADS ≤ 32.
  - Any other offset in the window, or an address outside the window: write ignored, read 0, still acked.
- Writes take effect only when wbs_sel_i[0]=1 (all fields lie in byte 0).
- SEL writes while LOCK=1 are ignored but acked. LOCK cannot be cleared by software.
- Function 0 is reserved "pad input only": io_oeb[p]=1, io_out[p]=0, regardless of func_*_i[0·NUM_PADS+p].
- Function f ≥ 1:
  - io_out[p] = func_out_i[f·NUM_PADS+p]
  - io_oeb[p] = ~func_oe_i[f·NUM_PADS+p]
- SEL value ≥ NUM_FUNC is treated as function 0.
- Input path: io_in passes through a SYNC_STAGES-flop synchroniser to s_in.
  - func_in_o[f·NUM_PADS+p] = s_in[p] when SEL[p]==f, else 0.
  - For f=0 this gives the GPIO read-back path.
- locked_o = LOCK.

## Timing
- Reset (wb_rst_i=1 at rising edge), all values in effect from the next cycle:
  - SEL all 0, LOCK=0, synchroniser flops 0.
  - wbs_ack_o=0, wbs_dat_o=0, hence io_oeb all 1, io_out all 0, func_in_o all 0.
- Wishbone handshake:
  - Request = wbs_stb_i & wbs_cyc_i & ~wbs_ack_o.
  - wbs_ack_o is registered: high for exactly 1 cycle, the cycle after the request.
  - wbs_dat_o is valid in the ack cycle and returns to 0 the following cycle.
  - With stb held high, transactions repeat every 2 cycles.
  - A request with cyc=0 is not acked.
- Write timing:
  - A write updates SEL/LOCK at the same edge that raises ack.
  - io_out/io_oeb reflect the new SEL in that ack cycle (combinational from SEL).
- Read/write ordering: a read issued right after a write returns the written value.
- Input latency: an io_in edge appears on func_in_o and IN_* after SYNC_STAGES cycles.
- Simultaneous LOCK=1 and SEL writes cannot occur (single port). Once the LOCK write is acked, every later SEL write is blocked.
- Reset during a pending request: the request is dropped, no ack issued.

## Test plan
- Reset: hold wb_rst_i 3 cycles with io_in=all 1.
  -> io_oeb all 1, io_out 0, wbs_ack_o 0, func_in_o 0; IN_LO reads 0x0000_0000 only on the first read cycle after reset if io_in toggled, else 0xFFFF_FFFF after SYNC_STAGES cycles.
- Route: write SEL[4]=2, then drive func_out_i bit 2·38+4 = 1 and func_oe_i same bit = 1.
  -> ack 1 cycle after stb; io_out[4]=1, io_oeb[4]=0; read SEL[4] returns 0x2.
- Input sync: SEL[10]=3, raise io_in[10] at cycle t.
  -> func_in_o[3·38+10] rises at t+2 (SYNC_STAGES=2); func_in_o[1·38+10] stays 0; IN_LO bit10=1.
- Lock: write LOCK=1, then write SEL[4]=1.
  -> both acked; SEL[4] still reads 2; locked_o=1; a reset then clears LOCK and SEL.
- Decode edges:
  - Write SEL[37]=3 -> reads back 3.
  - Write 0x098 (p=38) -> read 0.
  - Address BASE+0x200 -> acked, reads 0.
  - wbs_sel_i=4'b1110 write -> no change.
  - SEL value 5 with NUM_FUNC=4 -> pad behaves as function 0.
- Handshake: hold stb/cyc high for 6 cycles on a read.
  -> ack pattern 0,1,0,1,0,1; deasserting cyc mid-stream gives no further ack.
